// File: rtl/muldiv_iter_unit.sv
// Iterative 32x32 multiply / 32/32 divide unit owning HI/LO.
// Requests a pipeline stall while busy and reports completion once HI/LO hold the result.
module muldiv_iter_unit #(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        stall_e,
  input  logic        flush,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        alu_stall,
  output logic        alu_done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t        state_q, state_d;
  logic [5:0]    cnt_q, cnt_d;
  logic [1:0]    op_q;
  logic          sa_q, sb_q;
  logic [31:0]   ma_q, mb_q;
  logic [31:0]   opr_q, opr_d;
  logic [63:0]   acc_q, acc_d;
  logic [31:0]   hi_q, lo_q;

  logic          issue, fix_wr;
  logic          is_signed_i;
  logic [32:0]   mul_sum;
  logic [32:0]   div_sh;
  logic [33:0]   div_diff;
  logic signed [63:0] prod_res;
  logic [31:0]   quo_res, rem_res, a_raw;
  logic [31:0]   res_hi, res_lo;
  logic          neg_res;

  function automatic logic [31:0] neg32(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] x);
    return ~x + 64'd1;
  endfunction

  function automatic logic [31:0] mag32(input logic [31:0] x, input logic sgn);
    return (sgn && x[31]) ? neg32(x) : x;
  endfunction

  // Control: state and iteration counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    issue   = 1'b0;
    fix_wr  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          issue   = 1'b1;
          cnt_d   = 6'd0;
          state_d = CALC;
        end
      end
      CALC: begin
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(ITER - 1)) state_d = FIX;
      end
      FIX: begin
        fix_wr  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (!stall_e) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      issue   = 1'b0;
      fix_wr  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Iteration step: shift-add multiply on acc, restoring divide with acc[32:0] as remainder
  always_comb begin
    mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, (opr_q[0] ? ma_q : 32'd0)};
    div_sh   = {acc_q[31:0], opr_q[31]};
    div_diff = {1'b0, div_sh} - {2'b00, mb_q};
    if (op_q[1]) begin
      acc_d = {31'd0, (div_diff[33] ? div_sh : div_diff[32:0])};
      opr_d = {opr_q[30:0], ~div_diff[33]};
    end else begin
      acc_d = {mul_sum, acc_q[31:1]};
      opr_d = {1'b0, opr_q[31:1]};
    end
  end

  assign is_signed_i = ~op[0];

  always_ff @(posedge clk) begin
    if (issue) begin
      op_q  <= op;
      sa_q  <= is_signed_i & a[31];
      sb_q  <= is_signed_i & b[31];
      ma_q  <= mag32(a, is_signed_i);
      mb_q  <= mag32(b, is_signed_i);
      opr_q <= op[1] ? mag32(a, is_signed_i) : mag32(b, is_signed_i);
      acc_q <= 64'd0;
    end else if (state_q == CALC) begin
      acc_q <= acc_d;
      opr_q <= opr_d;
    end
  end

  // Sign fix-up of the unsigned magnitude result
  always_comb begin
    neg_res  = ~op_q[0] & (sa_q ^ sb_q);
    prod_res = neg_res ? $signed(neg64(acc_q)) : $signed(acc_q);
    quo_res  = neg_res ? neg32(opr_q) : opr_q;
    rem_res  = (~op_q[0] & sa_q) ? neg32(acc_q[31:0]) : acc_q[31:0];
    a_raw    = (~op_q[0] & sa_q) ? neg32(ma_q) : ma_q;
    if (op_q[1]) begin
      if (mb_q == 32'd0) begin
        res_hi = a_raw;
        res_lo = 32'hFFFF_FFFF;
      end else begin
        res_hi = rem_res;
        res_lo = quo_res;
      end
    end else begin
      res_hi = prod_res[63:32];
      res_lo = prod_res[31:0];
    end
  end

  // HI/LO: result commit beats a same-cycle MTHI/MTLO
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else if (fix_wr) begin
      hi_q <= res_hi;
      lo_q <= res_lo;
    end else begin
      if (hi_we) hi_q <= wdata;
      if (lo_we) lo_q <= wdata;
    end
  end

  assign alu_stall = ~flush & ((state_q != IDLE) | start);
  assign alu_done  = (state_q == DONE) & ~flush;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: doc/muldiv_iter_unit.md
# muldiv_iter_unit

Iterative 32-bit multiply/divide unit in the EX stage. It owns the HI/LO registers and drives the `alu_stall`/`alu_done` request pair consumed by the hazard/stall controller. While an operation is in flight it holds the pipeline in stall. It releases the pipeline with a done indication once HI/LO hold the result. The unit is the requester side of the controller's stall protocol: it asks for the stall, and the controller answers with `stall_e`/`flush`.

## Interface
Parameters:
- `ITER`, 32: iterations per operation; fixed by the 32-bit operand width.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `start`, in, 1: the EX instruction is MULT/MULTU/DIV/DIVU. Held high while EX is stalled.
- `op`, in, 2: operation select. 00 = MULT, 01 = MULTU, 10 = DIV, 11 = DIVU.
- `a`, in, 32: rs operand, after forwarding.
- `b`, in, 32: rt operand, after forwarding.
- `stall_e`, in, 1: StallE from the hazard controller.
- `flush`, in, 1: exception clean. Aborts any operation.
- `hi_we`, in, 1: MTHI write enable.
- `lo_we`, in, 1: MTLO write enable.
- `wdata`, in, 32: MTHI/MTLO data.
- `alu_stall`, out, 1: stall request.
- `alu_done`, out, 1: result committed; the EX instruction may advance.
- `hi`, out, 32: HI register.
- `lo`, out, 32: LO register.

## Operation
- States: IDLE, CALC, FIX, DONE. 6-bit iteration counter `cnt`.
- IDLE
  - When `start` is high and `flush` is low: latch `op`, |a|, |b|, sign(a) and sign(b).
    - Signed ops take two's-complement magnitude; unsigned ops take the raw value.
  - Clear the 64-bit accumulator, set `cnt`=0 and go to CALC.
- CALC: one iteration per cycle. `cnt` increments; go to FIX after `cnt`=31.
  - Multiply: shift-add on a 64-bit product.
  - Divide: restoring division with a 33-bit partial remainder.
- FIX
  - Multiply: negate the 64-bit product when the signed op has sign(a)≠sign(b). Then HI = product[63:32], LO = product[31:0].
  - Divide: LO = quotient, HI = remainder.
    - Signed: negate the quotient if signs differ; the remainder takes the sign of the dividend.
    - Divide by zero (b=0), any sign: HI = a, LO = 32'hFFFFFFFF.
  - Go to DONE.
- DONE: `alu_done`=1.
  - If `stall_e`=1, stay in DONE. This prevents re-issue while EX is held by another hazard.
  - Otherwise return to IDLE.
- `alu_stall` = !flush && ((state==IDLE && start) || state!=IDLE).
  - Combinational, so the controller stalls in the issue cycle itself.
- `alu_done` = (state==DONE) && !flush.
  - The controller sees `alu_stall && alu_done` and releases the pipeline.
- `flush`, any state: next state is IDLE. HI/LO are not written by the aborted operation.
- MTHI/MTLO: `hi_we`/`lo_we` write `wdata` at the clock edge, in any state.
  - The HI/LO write in FIX has priority over a same-cycle `hi_we`/`lo_we`.
  - `flush` does not block MTHI/MTLO writes; the controller does not issue them under flush.
- Operand width: 32 in, 64 result. There is no overflow exception.

## Timing
- Reset: state IDLE, `cnt`=0, `hi`=0, `lo`=0, `alu_stall`=0, `alu_done`=0. `rst` has priority over all inputs.
- Issue at cycle T (IDLE, `start`=1):
  - `alu_stall`=1 in T.
  - CALC runs T+1..T+32.
  - FIX at T+33.
  - DONE at T+34 with `alu_done`=1; HI/LO are valid from T+34.
- Total EX occupancy is 35 cycles when `stall_e` drops at T+34.
- `start` low in IDLE: `alu_stall`=0 and nothing is latched.
- Back-to-back ops:
  - The new op issues in the first IDLE cycle after DONE in which `start`=1.
  - The second op's `a`/`b` forwarding sees the updated HI/LO only via MFHI/MFLO; that is outside this block.
- Reset mid-CALC: next cycle is IDLE and HI/LO are 0.
- Flush in the issue cycle: `alu_stall`=0 and no latch.

## Test plan
- Start MULT with a=32'hFFFFFFFE (−2), b=3:
  - `alu_stall`=1 from T.
  - `alu_done` pulses at T+34.
  - HI=32'hFFFFFFFF, LO=32'hFFFFFFFA.
- Start MULTU with a=32'hFFFFFFFF, b=32'hFFFFFFFF: HI=32'hFFFFFFFE, LO=32'h00000001.
- Start DIV with a=−7, b=2: LO=32'hFFFFFFFD (−3), HI=32'hFFFFFFFF (−1).
- Start DIVU with a=100, b=0: HI=100, LO=32'hFFFFFFFF.
- Flush during the op:
  - Preload HI=LO=5 via MTHI/MTLO.
  - Start DIVU 10/3, then assert `flush` at T+10.
  - Required: IDLE at T+11, HI=LO=5 unchanged, `alu_stall`=0 from T+10.
- Held stall in DONE:
  - Hold `stall_e`=1 for 3 cycles after DONE is reached.
  - Required: `alu_done` stays 1 for 3 cycles, no re-issue, then IDLE; HI/LO hold a single result.
